// File: rtl/cache_pkg.sv
// Shared definitions for the cache set controller: controller state encoding,
// default widths and the set-count derivation.
package cache_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int OFFSET_W_DEF = 3;
    localparam int INDEX_W_DEF  = 2;
    localparam int CNT_W_DEF    = 32;
    localparam int LINE_W       = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_CHECK  = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_FETCH  = 3'd4,
        ST_UPDATE = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

    function automatic int num_sets(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] q
);

    // Count on inc, stop at all-ones; the hold path reloads q so the value
    // always comes from the register itself.
    always_ff @(posedge clk) begin
        if (clear)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + CNT_W'(1);
        else
            q <= q;
    end

endmodule

// File: rtl/cache_set_ctrl.sv
// Sequencer for an array of cache sets: one request at a time, search the
// indexed set, fetch the line from memory on a miss, then update the set and
// return the line with a hit flag. Also keeps hit/miss statistics.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// SEARCH | selected set looks up the tag
// CHECK  | sample the set's hit flag and data, bump a counter
// CLEAR  | hit path: update-with-no-write clears the set's sticky hit flag
// FETCH  | miss path: mem_req held until mem_ack
// UPDATE | miss path: push the fetched line into the set
// RESP   | one-cycle response pulse
module cache_set_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int TAG_W    = ADDR_W - OFFSET_W - INDEX_W,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_SETS = num_sets(INDEX_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    output logic                       resp_valid,
    output logic                       resp_hit,
    output logic [LINE_W-1:0]          resp_data,
    output logic [NUM_SETS-1:0]        set_en,
    output logic [TAG_W-1:0]           set_tag,
    output logic                       set_state,
    output logic                       set_mem_write,
    output logic [LINE_W-1:0]          set_write_data,
    input  logic [NUM_SETS-1:0]        set_hit,
    input  logic [NUM_SETS*LINE_W-1:0] set_read_data,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [LINE_W-1:0]          mem_rdata,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);

    localparam logic [NUM_SETS-1:0] ONE_SET = NUM_SETS'(1);

    state_t             state;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  rd_mux;
    logic               hit_inc;
    logic               miss_inc;
    logic               unused_offset;

    // Byte offset only selects a word inside the line; the controller ignores it.
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    // Read data of the currently indexed set.
    always_comb begin
        rd_mux = set_read_data[int'(idx)*LINE_W +: LINE_W];
    end

    assign hit_inc  = (state == ST_CHECK) &&  set_hit[idx];
    assign miss_inc = (state == ST_CHECK) && !set_hit[idx];

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .inc   (hit_inc),
        .clear (!rst_n),
        .q     (hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .inc   (miss_inc),
        .clear (!rst_n),
        .q     (miss_count)
    );

    // Controller FSM; every output is registered and computed for the state
    // being entered, so set_* strobes line up with SEARCH/CLEAR/UPDATE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            tag            <= '0;
            line_q         <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_data      <= '0;
            set_en         <= '0;
            set_tag        <= '0;
            set_state      <= 1'b0;
            set_mem_write  <= 1'b0;
            set_write_data <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
        end else begin
            resp_valid     <= 1'b0;
            set_en         <= '0;
            set_tag        <= '0;
            set_state      <= 1'b0;
            set_mem_write  <= 1'b0;
            set_write_data <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx       <= req_addr[OFFSET_W +: INDEX_W];
                        tag       <= req_addr[ADDR_W-1 -: TAG_W];
                        req_ready <= 1'b0;
                        set_en    <= ONE_SET << req_addr[OFFSET_W +: INDEX_W];
                        set_tag   <= req_addr[ADDR_W-1 -: TAG_W];
                        state     <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (set_hit[idx]) begin
                        line_q    <= rd_mux;
                        resp_hit  <= 1'b1;
                        set_en    <= ONE_SET << idx;
                        set_tag   <= tag;
                        set_state <= 1'b1;
                        state     <= ST_CLEAR;
                    end else begin
                        resp_hit <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= {tag, idx, {OFFSET_W{1'b0}}};
                        state    <= ST_FETCH;
                    end
                end
                ST_CLEAR: begin
                    resp_valid <= 1'b1;
                    resp_data  <= line_q;
                    state      <= ST_RESP;
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        line_q         <= mem_rdata;
                        mem_req        <= 1'b0;
                        mem_addr       <= '0;
                        set_en         <= ONE_SET << idx;
                        set_tag        <= tag;
                        set_state      <= 1'b1;
                        set_mem_write  <= 1'b1;
                        set_write_data <= mem_rdata;
                        state          <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    resp_valid <= 1'b1;
                    resp_data  <= line_q;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl: the bench plays the set array and memory.
module tb_cache_set_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          resp_valid;
    logic          resp_hit;
    logic [63:0]   resp_data;
    logic [3:0]    set_en;
    logic [26:0]   set_tag;
    logic          set_state;
    logic          set_mem_write;
    logic [63:0]   set_write_data;
    logic [3:0]    set_hit;
    logic [255:0]  set_read_data;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [63:0]   mem_rdata;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    int checks = 0;
    int failures = 0;

    // observations filled by do_req
    int          obs_lat;
    logic        obs_hit;
    logic [63:0] obs_data;
    logic [3:0]  obs_en_or;
    bit          obs_multi;
    bit          obs_leak;
    bit          obs_clear;
    logic [3:0]  obs_clear_en;
    bit          obs_upd;
    logic [3:0]  obs_upd_en;
    logic [63:0] obs_upd_wdata;
    logic [26:0] obs_upd_tag;
    logic [31:0] obs_mem_addr;
    int          obs_fetch_n;

    localparam logic [63:0] LINE_A = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] LINE_B = 64'h0F0E_0D0C_0B0A_0908;
    localparam logic [63:0] LINE_C = 64'h5555_AAAA_3333_CCCC;

    cache_set_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_data      (resp_data),
        .set_en         (set_en),
        .set_tag        (set_tag),
        .set_state      (set_state),
        .set_mem_write  (set_mem_write),
        .set_write_data (set_write_data),
        .set_hit        (set_hit),
        .set_read_data  (set_read_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    // Issue one request starting at a negedge and follow it to resp_valid.
    // The memory acks ack_wait cycles after mem_req is first seen.
    task automatic do_req(input logic [31:0] addr, input logic hit,
                          input logic [63:0] line, input int ack_wait);
        bit done;
        set_hit       = hit ? (4'b0001 << addr[4:3]) : 4'b0000;
        obs_lat       = -1;
        obs_hit       = 1'bx;
        obs_data      = '0;
        obs_en_or     = '0;
        obs_multi     = 0;
        obs_leak      = 0;
        obs_clear     = 0;
        obs_clear_en  = '0;
        obs_upd       = 0;
        obs_upd_en    = '0;
        obs_upd_wdata = '0;
        obs_upd_tag   = '0;
        obs_mem_addr  = '0;
        obs_fetch_n   = -1;
        done          = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 80 && !done; n++) begin
            obs_en_or = obs_en_or | set_en;
            if ($countones(set_en) > 1) obs_multi = 1;
            if (set_en == 4'b0000 && (set_tag != '0 || set_state || set_mem_write || set_write_data != '0))
                obs_leak = 1;
            if (set_en != 4'b0000 && set_state && !set_mem_write) begin
                obs_clear    = 1;
                obs_clear_en = set_en;
            end
            if (set_en != 4'b0000 && set_mem_write) begin
                obs_upd       = 1;
                obs_upd_en    = set_en;
                obs_upd_wdata = set_write_data;
                obs_upd_tag   = set_tag;
            end
            if (mem_req) begin
                if (obs_fetch_n < 0) obs_fetch_n = n;
                obs_mem_addr = mem_addr;
            end
            mem_ack   = (obs_fetch_n >= 0 && n == obs_fetch_n + ack_wait);
            mem_rdata = line;
            if (resp_valid) begin
                obs_lat  = n;
                obs_hit  = resp_hit;
                obs_data = resp_data;
                done     = 1;
            end else begin
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if ({resp_valid, mem_req, set_en, set_state, set_mem_write} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {resp_valid, mem_req, set_en, set_state, set_mem_write});
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got hit=%0d miss=%0d exp 0/0", hit_count, miss_count);
        end
    endtask

    task automatic test_reset_in_fetch;
        bit saw_fetch = 0;
        bit bad_ready = 0;
        bit bad_req = 0;
        bit bad_resp = 0;
        set_hit   = 4'b0000;
        req_valid = 1'b1;
        req_addr  = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 0; n < 10 && !saw_fetch; n++) begin
            if (mem_req) saw_fetch = 1;
            else @(negedge clk);
        end
        checks++;
        if (!saw_fetch) begin
            failures++;
            $display("FAIL rstfetch_mem_req got=0 exp=1 within 10 cycles");
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = LINE_C;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (req_ready !== 1'b1) bad_ready = 1;
            if (mem_req !== 1'b0) bad_req = 1;
            if (resp_valid !== 1'b0) bad_resp = 1;
            @(negedge clk);
        end
        checks++;
        if (bad_ready) begin
            failures++;
            $display("FAIL rstfetch_req_ready got=0 exp=1");
        end
        checks++;
        if (bad_req || bad_resp) begin
            failures++;
            $display("FAIL rstfetch_quiet got mem_req_bad=%0d resp_bad=%0d exp 0/0", bad_req, bad_resp);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            failures++;
            $display("FAIL rstfetch_counters got hit=%0d miss=%0d exp 0/0", hit_count, miss_count);
        end
    endtask

    task automatic test_cold_miss;
        do_req(32'h0000_1008, 1'b0, LINE_A, 3);
        checks++;
        if (obs_lat != 8) begin
            failures++;
            $display("FAIL miss_latency got=%0d exp=8", obs_lat);
        end
        checks++;
        if (obs_hit !== 1'b0 || obs_data !== LINE_A) begin
            failures++;
            $display("FAIL miss_resp got hit=%b data=%h exp hit=0 data=%h", obs_hit, obs_data, LINE_A);
        end
        checks++;
        if (!obs_upd || obs_upd_en !== 4'b0010 || obs_upd_wdata !== LINE_A || obs_upd_tag !== 27'h80) begin
            failures++;
            $display("FAIL miss_update got seen=%0d en=%b wd=%h tag=%h exp en=0010 wd=%h tag=80",
                     obs_upd, obs_upd_en, obs_upd_wdata, obs_upd_tag, LINE_A);
        end
        checks++;
        if (obs_mem_addr !== 32'h0000_1008) begin
            failures++;
            $display("FAIL miss_mem_addr got=%h exp=00001008", obs_mem_addr);
        end
        checks++;
        if (obs_multi || obs_leak) begin
            failures++;
            $display("FAIL miss_set_bus got multi=%0d leak=%0d exp 0/0", obs_multi, obs_leak);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd1) begin
            failures++;
            $display("FAIL miss_counters got hit=%0d miss=%0d exp 0/1", hit_count, miss_count);
        end
    endtask

    task automatic test_hit_repeat;
        set_read_data = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, LINE_A, 64'h1111_1111_1111_1111};
        do_req(32'h0000_1008, 1'b1, LINE_C, 0);
        checks++;
        if (obs_lat != 4) begin
            failures++;
            $display("FAIL hit_latency got=%0d exp=4", obs_lat);
        end
        checks++;
        if (obs_hit !== 1'b1 || obs_data !== LINE_A) begin
            failures++;
            $display("FAIL hit_resp got hit=%b data=%h exp hit=1 data=%h", obs_hit, obs_data, LINE_A);
        end
        checks++;
        if (!obs_clear || obs_clear_en !== 4'b0010 || obs_upd) begin
            failures++;
            $display("FAIL hit_clear got seen=%0d en=%b write=%0d exp seen=1 en=0010 write=0",
                     obs_clear, obs_clear_en, obs_upd);
        end
        checks++;
        if (obs_fetch_n >= 0) begin
            failures++;
            $display("FAIL hit_no_fetch got mem_req at cycle %0d exp none", obs_fetch_n);
        end
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            failures++;
            $display("FAIL hit_counters got hit=%0d miss=%0d exp 1/1", hit_count, miss_count);
        end
    endtask

    task automatic test_line_align;
        do_req(32'h0000_101C, 1'b0, LINE_B, 1);
        checks++;
        if (obs_mem_addr !== 32'h0000_1018) begin
            failures++;
            $display("FAIL align_mem_addr got=%h exp=00001018", obs_mem_addr);
        end
        checks++;
        if (obs_en_or !== 4'b1000 || obs_multi) begin
            failures++;
            $display("FAIL align_set_en got or=%b multi=%0d exp or=1000 multi=0", obs_en_or, obs_multi);
        end
        checks++;
        if (obs_lat != 6 || obs_data !== LINE_B) begin
            failures++;
            $display("FAIL align_resp got lat=%0d data=%h exp lat=6 data=%h", obs_lat, obs_data, LINE_B);
        end
        checks++;
        if (miss_count !== 32'd2) begin
            failures++;
            $display("FAIL align_miss_count got=%0d exp=2", miss_count);
        end
    endtask

    task automatic test_back_to_back;
        int  accepts = 0;
        int  resps = 0;
        bit  inflight = 0;
        bit  ready_bad = 0;
        bit  saw_mem_req = 0;
        bit  all_hit = 1;
        set_hit   = 4'b0010;
        req_addr  = 32'h0000_1008;
        req_valid = 1'b1;
        for (int n = 0; n < 100 && resps < 3; n++) begin
            mem_ack = (set_en != 4'b0000) && !set_state;
            if (mem_req) saw_mem_req = 1;
            if (resp_valid) begin
                resps++;
                inflight = 0;
                if (resp_hit !== 1'b1 || resp_data !== LINE_A) all_hit = 0;
                if (resps == 3) req_valid = 1'b0;
            end
            if (req_ready) begin
                if (inflight) ready_bad = 1;
                if (req_valid) begin
                    accepts++;
                    inflight = 1;
                end
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        repeat (6) begin
            if (req_ready && req_valid) accepts++;
            if (mem_req) saw_mem_req = 1;
            @(negedge clk);
        end
        checks++;
        if (accepts != 3 || resps != 3) begin
            failures++;
            $display("FAIL b2b_accepts got acc=%0d resp=%0d exp 3/3", accepts, resps);
        end
        checks++;
        if (ready_bad) begin
            failures++;
            $display("FAIL b2b_ready got ready=1 while busy exp 0");
        end
        checks++;
        if (saw_mem_req || !all_hit) begin
            failures++;
            $display("FAIL b2b_spurious_ack got mem_req=%0d all_hit=%0d exp 0/1", saw_mem_req, all_hit);
        end
        checks++;
        if (hit_count !== 32'd4 || miss_count !== 32'd2) begin
            failures++;
            $display("FAIL b2b_counters got hit=%0d miss=%0d exp 4/2", hit_count, miss_count);
        end
    endtask

    task automatic test_saturate;
        force dut.u_miss_cnt.q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.u_miss_cnt.q;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (miss_count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sat_preload got=%h exp=ffffffff", miss_count);
        end
        do_req(32'h0000_3000, 1'b0, LINE_C, 0);
        checks++;
        if (obs_lat != 5 || obs_data !== LINE_C || obs_hit !== 1'b0) begin
            failures++;
            $display("FAIL sat_resp got lat=%0d hit=%b data=%h exp lat=5 hit=0 data=%h",
                     obs_lat, obs_hit, obs_data, LINE_C);
        end
        checks++;
        if (miss_count !== 32'hFFFF_FFFF || hit_count !== 32'd4) begin
            failures++;
            $display("FAIL sat_hold got miss=%h hit=%0d exp miss=ffffffff hit=4", miss_count, hit_count);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        set_hit       = '0;
        set_read_data = '0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset_in_fetch;
        test_cold_miss;
        @(negedge clk);
        test_hit_repeat;
        @(negedge clk);
        test_line_align;
        @(negedge clk);
        test_back_to_back;
        test_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
